shared_data_mem: RTL and testbench
==================================

Name: shared_data_mem

Overview:
- Next-generation multi-core data memory: one shared single-port array of 2**Lmem words, each TAM bits wide.
- Serves Ncores load/store ports through a round-robin arbiter, one access per cycle.
- Adds a per-core acknowledge handshake and a post-reset zero-fill sequencer.
- Sits between the core pipelines' MEM stages and the data storage; replaces the ungated per-core DataMEM access.

Parameters:
- Ncores, 2, number of core ports (>=1).
- Lmem, 8, address width; depth = 2**Lmem words.
- TAM, 16, data word width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- dataIN  in  Ncores*TAM  store data; core k uses bits [k*TAM +: TAM].
- dataADDR  in  Ncores*Lmem  word address; core k uses bits [k*Lmem +: Lmem].
- dataLoad  in  Ncores  load request per core; level, held until ack.
- dataWrite  in  Ncores  store request per core; level, held until ack.
- dataOUT  out  Ncores*TAM  registered load data per core.
- dataAck  out  Ncores  one-cycle acknowledge per core.
- memReady  out  1  high once zero-fill is complete.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-low.
- Outputs while rst=0:
  - dataOUT = 0, dataAck = 0, memReady = 0.
  - FSM goes to INIT, fill counter = 0, round-robin pointer = 0.
- FSM states:
  - INIT: writes 0 to address fillCnt each cycle and increments fillCnt. Requests are ignored and no acks are issued. When fillCnt = 2**Lmem-1 is written, go to SERVE; memReady is high from the next cycle onward. INIT lasts exactly 2**Lmem cycles after rst deasserts.
  - SERVE: normal operation. Left only by reset. Reset in any state, including mid-fill, restarts INIT from address 0.
- Request per core: req[k] = (dataLoad[k] | dataWrite[k]) & ~dataAck[k].
  - The ack mask stops a core whose request is still high during its ack cycle from being re-granted.
  - dataLoad and dataWrite both high on one core: treated as a store; no load data is returned.
- Arbitration, SERVE only, combinational within the cycle:
  - Search req starting at index ptr, wrapping modulo Ncores. The first set bit is grant g.
  - No request: no grant, ptr unchanged.
  - On a grant, ptr <= (g+1) mod Ncores at the clock edge.
- Access at the clock edge ending grant cycle t:
  - Store: mem[dataADDR[g]] <= dataIN[g].
  - Load: dataOUT[g] <= mem[dataADDR[g]], read-before-write irrelevant since only one access per cycle.
  - dataAck[g] <= 1 for cycle t+1 only. All other dataAck bits are 0.
- Latency and data hold:
  - Best-case latency is request at t, ack and data at t+1.
  - Worst case with all cores contending is Ncores cycles to grant.
  - dataOUT[k] holds its value until core k's next load completes; stores do not change it.
- Core protocol:
  - A core keeps its request and operands stable until it sees the ack.
  - It deasserts or presents a new request in the cycle after the ack.
  - Operand changes before the ack are undefined behaviour and are not checked.
- Address width is exactly Lmem bits, with no out-of-range case.
- Ncores=1: the arbiter degenerates. Back-to-back held requests are served every other cycle because of the ack mask.

Decomposition:
- Shared package nrisc_mem_pkg:
  - FSM state enum {INIT, SERVE}.
  - Localparam DEPTH = 2**Lmem.
  - Helper function for the pointer width, clog2(Ncores) with a minimum of 1.
- One sub-module, rr_arbiter:
  - Parameter N; inputs clk, rst, req[N]; outputs grant one-hot [N], grant index, grant valid.
  - Owns the rotating pointer. Reused later for the instruction-memory port.

Test Plan (Ncores=2, Lmem=8, TAM=16):
- Reset/fill:
  - Stimulus: rst low 3 cycles, then high.
  - Required: memReady=0 for exactly 256 cycles, then 1. Loads of addresses 0x00, 0x7F and 0xFF return 0x0000. No ack while memReady=0, even with requests held.
- Single store/load:
  - Stimulus: core0 stores 0xBEEF to 0x12, then loads 0x12.
  - Required: ack each one cycle after request; dataOUT[0]=0xBEEF; dataOUT[1] unchanged at 0.
- Contention:
  - Stimulus: both cores load in the same cycle with ptr=0. Core0 reads 0x01 (holds 0x1111), core1 reads 0x02 (holds 0x2222).
  - Required: ack0 at t+1, ack1 at t+2, correct data on each port. Repeating the request puts core1 first (ack1 at t+1).
- Store/load hazard:
  - Stimulus: core1 stores 0xA5A5 to 0x40 while core0 loads 0x40 in the same cycle, ptr=1.
  - Required: store served first; core0 then reads 0xA5A5.
- Held request:
  - Stimulus: core0 holds dataLoad continuously.
  - Required: acks at alternate cycles, never two consecutive acks. Both load and write set: treated as a store, mem updated, dataOUT unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during contention and at fill address 0x80.
  - Required: dataAck cleared next cycle, memReady=0, fill restarts at 0x00 and takes a full 256 cycles, earlier stores read back as 0.

Source files
------------

// File: rtl/nrisc_mem_pkg.sv
// Shared types and sizing helpers for the shared data memory and its arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package nrisc_mem_pkg;

   // Sequencer states: zero-fill after reset, then normal load/store service
   typedef enum logic {
      INIT  = 1'b0,
      SERVE = 1'b1
   } mem_state_t;

   // Default geometry of the data memory
   localparam int LMEM_DEFAULT = 8;
   localparam int DEPTH        = 2 ** LMEM_DEFAULT;

   // Number of words addressed by an lmem-bit address
   function automatic int mem_depth(input int lmem);
      return 2 ** lmem;
   endfunction

   // Width of a core index / round-robin pointer; a single core still needs one bit
   function automatic int ptr_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shared_data_mem_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the rotating pointer.
// Latency: grant is combinational in the request cycle; pointer moves at the edge.
// Backpressure: requesters not granted simply stay pending; no internal queueing.
module rr_arbiter
   import nrisc_mem_pkg::*;
#(
   parameter int N = 2
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req,
   output logic [N-1:0]            grant,
   output logic [ptr_width(N)-1:0] grant_idx,
   output logic                    grant_vld
);

   localparam int PW = ptr_width(N);

   logic [PW-1:0] ptr;
   logic [N-1:0]  rot;
   int            sum;

   // Rotate requests so that bit 0 is the core the pointer currently favours
   assign rot = N'({req, req} >> ptr);

   // First set bit of the rotated vector, mapped back to a real core index
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      sum       = 0;
      for (int i = 0; i < N; i++) begin
         if (!grant_vld && rot[i]) begin
            grant_vld = 1'b1;
            sum       = int'(ptr) + i;
            if (sum >= N) begin
               sum = sum - N;
            end
            grant_idx = PW'(sum);
         end
      end
   end

   assign grant = grant_vld ? (N'(1) << grant_idx) : '0;

   // Pointer advances past the winner so it has lowest priority next time
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
      end else if (grant_vld) begin
         if (int'(grant_idx) == N - 1) begin
            ptr <= '0;
         end else begin
            ptr <= grant_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_data_mem.sv
// Shared single-port data memory serving Ncores load/store ports, one access per cycle.
// Latency: request at t, registered ack and load data at t+1 when uncontended.
// Backpressure: requests are level and held until the one-cycle ack; no acks until zero-fill completes.
module shared_data_mem
   import nrisc_mem_pkg::*;
#(
   parameter int Ncores = 2,
   parameter int Lmem   = 8,
   parameter int TAM    = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [Ncores*TAM-1:0]  dataIN,
   input  logic [Ncores*Lmem-1:0] dataADDR,
   input  logic [Ncores-1:0]      dataLoad,
   input  logic [Ncores-1:0]      dataWrite,
   output logic [Ncores*TAM-1:0]  dataOUT,
   output logic [Ncores-1:0]      dataAck,
   output logic                   memReady
);

   localparam int MEM_DEPTH = mem_depth(Lmem);
   localparam int PW        = ptr_width(Ncores);

   mem_state_t      state;
   mem_state_t      state_nx;
   logic [Lmem-1:0] fill_cnt;
   logic [Lmem-1:0] fill_nx;

   logic [TAM-1:0]  mem [MEM_DEPTH];

   logic [Ncores-1:0] req;
   logic [Ncores-1:0] grant;
   logic [PW-1:0]     grant_idx;
   logic              grant_vld;

   logic [Lmem-1:0] acc_addr;
   logic [TAM-1:0]  acc_wdata;
   logic            acc_store;
   logic            acc_load;

   logic            mem_we;
   logic [Lmem-1:0] mem_addr;
   logic [TAM-1:0]  mem_wdata;
   logic [TAM-1:0]  rd_data;

   // A core that is being acked this cycle is masked so a still-high request
   // is not granted twice; nothing is eligible until the fill has finished.
   assign req = (dataLoad | dataWrite) & ~dataAck & {Ncores{state == SERVE}};

   rr_arbiter #(
      .N (Ncores)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Select the granted core's operands
   always_comb begin
      acc_addr  = '0;
      acc_wdata = '0;
      for (int k = 0; k < Ncores; k++) begin
         if (grant_vld && int'(grant_idx) == k) begin
            acc_addr  = dataADDR[k*Lmem +: Lmem];
            acc_wdata = dataIN[k*TAM +: TAM];
         end
      end
   end

   // Store wins when a core raises both load and store
   assign acc_store = |(dataWrite & grant);
   assign acc_load  = |(dataLoad & ~dataWrite & grant);

   // Next-state and memory-port control: fill sweep in INIT, granted access in SERVE
   always_comb begin
      state_nx  = state;
      fill_nx   = fill_cnt;
      mem_we    = 1'b0;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
      case (state)
         INIT: begin
            mem_we    = 1'b1;
            mem_addr  = fill_cnt;
            mem_wdata = '0;
            fill_nx   = fill_cnt + 1'b1;
            if (fill_cnt == {Lmem{1'b1}}) begin
               state_nx = SERVE;
            end
         end
         SERVE: begin
            mem_we = acc_store;
         end
         default: begin
            state_nx = INIT;
         end
      endcase
   end

   // Sequencer state and fill counter; reset always restarts the fill from address 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= INIT;
         fill_cnt <= '0;
      end else begin
         state    <= state_nx;
         fill_cnt <= fill_nx;
      end
   end

   // Single write port of the storage array
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign rd_data = mem[acc_addr];

   // Registered ack and per-core load data; stores leave dataOUT untouched
   always_ff @(posedge clk) begin
      if (!rst) begin
         dataAck <= '0;
         dataOUT <= '0;
      end else begin
         dataAck <= grant;
         for (int k = 0; k < Ncores; k++) begin
            if (acc_load && grant[k]) begin
               dataOUT[k*TAM +: TAM] <= rd_data;
            end
         end
      end
   end

   assign memReady = (state == SERVE);

endmodule

// File: tb/tb_shared_data_mem.sv
// Self-checking bench for shared_data_mem with two cores, 256 x 16-bit words.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: bench cores hold each request until its ack, as real cores do.
module tb_shared_data_mem;

   localparam int NC = 2;
   localparam int LM = 8;
   localparam int TW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC*TW-1:0]  dataIN;
   logic [NC*LM-1:0]  dataADDR;
   logic [NC-1:0]     dataLoad;
   logic [NC-1:0]     dataWrite;
   logic [NC*TW-1:0]  dataOUT;
   logic [NC-1:0]     dataAck;
   logic              memReady;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          core;
      logic        ld;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] din;
      logic [15:0] exp0;
      logic [15:0] exp1;
   } vec_t;

   vec_t vecs [9];

   // Reference memory contents and per-core load registers for the random phase
   logic [15:0] mm [256];

   shared_data_mem #(
      .Ncores (NC),
      .Lmem   (LM),
      .TAM    (TW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dataIN    (dataIN),
      .dataADDR  (dataADDR),
      .dataLoad  (dataLoad),
      .dataWrite (dataWrite),
      .dataOUT   (dataOUT),
      .dataAck   (dataAck),
      .memReady  (memReady)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int c, input logic ld, input logic wr,
                          input logic [7:0] a, input logic [15:0] d);
      dataLoad[c]           = ld;
      dataWrite[c]          = wr;
      dataADDR[c*LM +: LM]  = a;
      dataIN[c*TW +: TW]    = d;
   endtask

   // Counts cycles with memReady low starting from the current cycle
   task automatic wait_fill(input string name, input int exp_len);
      int n;
      bit saw_ack;
      n       = 0;
      saw_ack = 1'b0;
      while (memReady !== 1'b1 && n < 600) begin
         if (dataAck !== 2'b00) saw_ack = 1'b1;
         tick();
         n++;
      end
      check({name, "_len"}, n, exp_len);
      check({name, "_noack"}, {31'd0, saw_ack}, 32'd0);
   endtask

   task automatic run_random(input int ncyc, input int start_ptr);
      bit          pend [2];
      logic        pld  [2];
      logic        pwr  [2];
      logic [7:0]  pa   [2];
      logic [15:0] pd   [2];
      logic [15:0] mout [2];
      logic [1:0]  mack;
      logic [1:0]  nack;
      int          mptr;
      int          g;
      int          idx;
      int          kind;
      mptr = start_ptr;
      mack = 2'b00;
      for (int k = 0; k < 2; k++) begin
         pend[k] = 1'b0; pld[k] = 1'b0; pwr[k] = 1'b0; pa[k] = '0; pd[k] = '0;
         mout[k] = 16'h0000;
      end
      for (int c = 0; c < ncyc; c++) begin
         for (int k = 0; k < 2; k++) begin
            set_req(k, pend[k] & pld[k], pend[k] & pwr[k], pa[k], pd[k]);
         end
         // Round-robin choice among cores with a live request not acked this cycle
         g    = -1;
         nack = 2'b00;
         for (int i = 0; i < 2; i++) begin
            idx = (mptr + i) % 2;
            if (g < 0 && pend[idx] && !mack[idx]) g = idx;
         end
         if (g >= 0) begin
            nack[g] = 1'b1;
            if (pwr[g]) mm[pa[g]] = pd[g];
            else        mout[g]   = mm[pa[g]];
            mptr = (g + 1) % 2;
         end
         tick();
         check("rnd_ack", {30'd0, dataAck}, {30'd0, nack});
         check("rnd_out", dataOUT, {mout[1], mout[0]});
         mack = nack;
         for (int k = 0; k < 2; k++) begin
            if (mack[k] || !pend[k]) begin
               kind    = $urandom_range(0, 3);
               pend[k] = (kind != 3);
               pld[k]  = (kind == 0) || (kind == 2);
               pwr[k]  = (kind == 1) || (kind == 2);
               pa[k]   = 8'($urandom_range(0, 15));
               pd[k]   = 16'($urandom);
            end
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b0;
      dataIN    = '0;
      dataADDR  = '0;
      dataLoad  = '0;
      dataWrite = '0;

      vecs[0] = '{0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{1, 1'b1, 1'b0, 8'h7F, 16'h0000, 16'h0000, 16'h0000};
      vecs[2] = '{0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'h0000, 16'h0000};
      vecs[3] = '{0, 1'b0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, 16'h0000};
      vecs[4] = '{0, 1'b1, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 16'h0000};
      vecs[5] = '{0, 1'b0, 1'b1, 8'h01, 16'h1111, 16'hBEEF, 16'h0000};
      vecs[6] = '{1, 1'b0, 1'b1, 8'h02, 16'h2222, 16'hBEEF, 16'h0000};
      vecs[7] = '{1, 1'b1, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 16'hBEEF};
      vecs[8] = '{1, 1'b1, 1'b0, 8'h7F, 16'h0000, 16'hBEEF, 16'h0000};

      // Reset, then fill with a request held throughout
      repeat (3) tick();
      check("rst_ack", {30'd0, dataAck}, 32'd0);
      check("rst_out", dataOUT, 32'd0);
      check("rst_ready", {31'd0, memReady}, 32'd0);
      set_req(1, 1'b1, 1'b0, 8'h05, 16'h0000);
      rst = 1'b1;
      wait_fill("fill_initial", 256);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("post_fill_ready", {31'd0, memReady}, 32'd1);
      check("post_fill_noack", {30'd0, dataAck}, 32'd0);

      // Table of single-core transactions, each acked one cycle after request
      for (int i = 0; i < 9; i++) begin
         set_req(vecs[i].core, vecs[i].ld, vecs[i].wr, vecs[i].addr, vecs[i].din);
         tick();
         check($sformatf("vec%0d_ack", i), {30'd0, dataAck}, 32'd1 << vecs[i].core);
         check($sformatf("vec%0d_out0", i), {16'd0, dataOUT[15:0]}, {16'd0, vecs[i].exp0});
         check($sformatf("vec%0d_out1", i), {16'd0, dataOUT[31:16]}, {16'd0, vecs[i].exp1});
         set_req(vecs[i].core, 1'b0, 1'b0, 8'h00, 16'h0000);
         tick();
         check($sformatf("vec%0d_idle", i), {30'd0, dataAck}, 32'd0);
      end

      // Contention with pointer at core 0
      set_req(0, 1'b1, 1'b0, 8'h01, 16'h0000);
      set_req(1, 1'b1, 1'b0, 8'h02, 16'h0000);
      tick();
      check("cont1_ack_t1", {30'd0, dataAck}, 32'b01);
      check("cont1_out0", {16'd0, dataOUT[15:0]}, 32'h1111);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("cont1_ack_t2", {30'd0, dataAck}, 32'b10);
      check("cont1_out1", {16'd0, dataOUT[31:16]}, 32'h2222);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("cont1_idle", {30'd0, dataAck}, 32'd0);

      // Lone core0 access moves the pointer to core 1
      set_req(0, 1'b1, 1'b0, 8'h02, 16'h0000);
      tick();
      check("solo_out0", {16'd0, dataOUT[15:0]}, 32'h2222);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();

      // Contention again: core1 now wins first
      set_req(0, 1'b1, 1'b0, 8'h01, 16'h0000);
      set_req(1, 1'b1, 1'b0, 8'h12, 16'h0000);
      tick();
      check("cont2_ack_t1", {30'd0, dataAck}, 32'b10);
      check("cont2_out1", {16'd0, dataOUT[31:16]}, 32'hBEEF);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("cont2_ack_t2", {30'd0, dataAck}, 32'b01);
      check("cont2_out0", {16'd0, dataOUT[15:0]}, 32'h1111);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();

      // Store/load hazard on the same address with pointer at core 1
      set_req(0, 1'b1, 1'b0, 8'h40, 16'h0000);
      set_req(1, 1'b0, 1'b1, 8'h40, 16'hA5A5);
      tick();
      check("haz_ack_store", {30'd0, dataAck}, 32'b10);
      check("haz_out1_kept", {16'd0, dataOUT[31:16]}, 32'hBEEF);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("haz_ack_load", {30'd0, dataAck}, 32'b01);
      check("haz_out0", {16'd0, dataOUT[15:0]}, 32'hA5A5);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();

      // Held load: acks on alternate cycles only
      set_req(0, 1'b1, 1'b0, 8'h12, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("held_ack%0d", i), {30'd0, dataAck}, (i % 2 == 0) ? 32'b01 : 32'b00);
      end
      check("held_out0", {16'd0, dataOUT[15:0]}, 32'hBEEF);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("held_idle", {30'd0, dataAck}, 32'd0);

      // Load and store together behave as a store
      set_req(0, 1'b1, 1'b1, 8'h33, 16'h7777);
      tick();
      check("both_ack", {30'd0, dataAck}, 32'b01);
      check("both_out0_kept", {16'd0, dataOUT[15:0]}, 32'hBEEF);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      set_req(0, 1'b1, 1'b0, 8'h33, 16'h0000);
      tick();
      check("both_readback", {16'd0, dataOUT[15:0]}, 32'h7777);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();

      // Reset during contention, then again at fill address 0x80
      set_req(0, 1'b1, 1'b0, 8'h01, 16'h0000);
      set_req(1, 1'b1, 1'b0, 8'h02, 16'h0000);
      tick();
      check("midop_ack", {30'd0, dataAck}, 32'b10);
      check("midop_out1", {16'd0, dataOUT[31:16]}, 32'h2222);
      rst = 1'b0;
      tick();
      check("midop_rst_ack", {30'd0, dataAck}, 32'd0);
      check("midop_rst_ready", {31'd0, memReady}, 32'd0);
      check("midop_rst_out", dataOUT, 32'd0);
      rst = 1'b1;
      repeat (128) tick();
      check("partial_fill_ready", {31'd0, memReady}, 32'd0);
      check("partial_fill_noack", {30'd0, dataAck}, 32'd0);
      rst = 1'b0;
      tick();
      check("refill_rst_ready", {31'd0, memReady}, 32'd0);
      rst = 1'b1;
      wait_fill("fill_restart", 256);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("refill_noack", {30'd0, dataAck}, 32'd0);

      // Earlier stores are wiped by the new fill
      set_req(0, 1'b1, 1'b0, 8'h12, 16'h0000);
      set_req(1, 1'b1, 1'b0, 8'h40, 16'h0000);
      tick();
      check("wipe_ack0", {30'd0, dataAck}, 32'b01);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      check("wipe_ack1", {30'd0, dataAck}, 32'b10);
      check("wipe_out", dataOUT, 32'd0);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(0, 1'b1, 1'b0, 8'h33, 16'h0000);
      tick();
      check("wipe_33", {16'd0, dataOUT[15:0]}, 32'h0000);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick();

      // Randomized traffic against the reference model; pointer now at core 1
      for (int a = 0; a < 256; a++) mm[a] = 16'h0000;
      run_random(400, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
